// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
// State encoding is kept as plain localparams on a 2-bit type.
package serial_add_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t RUN  = 2'd1;
   localparam state_t DONE = 2'd2;

   localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// Single-bit full adder cell; the sequencer's only arithmetic element.
module Full_Adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one Full_Adder cell, LSB-first, WIDTH cycles per add.
// Optional subtract mode via SERIAL_ADD_SUB_EN (adds the sub input).
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             fa_s;
   logic             fa_cout;
   logic [WIDTH-1:0] sum_shift;
   logic [WIDTH-1:0] b_load;
   logic             carry_load;

   Full_Adder u_fa (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .cin  (carry_q),
      .s    (fa_s),
      .cout (fa_cout)
   );

   // New sum bit enters at the MSB so bit 0 ends up at sum[0] after WIDTH shifts.
   generate
      if (WIDTH == 1) begin : g_sum_w1
         assign sum_shift = fa_s;
      end else begin : g_sum_wn
         assign sum_shift = {fa_s, sum_q[WIDTH-1:1]};
      end
   endgenerate

`ifdef SERIAL_ADD_SUB_EN
   // Two's-complement subtract: invert B and force carry-in to 1.
   assign b_load     = sub ? ~op_b : op_b;
   assign carry_load = sub ? 1'b1 : cin;
`else
   assign b_load     = op_b;
   assign carry_load = cin;
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = op_a;
               b_d     = b_load;
               carry_d = carry_load;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            sum_d   = sum_shift;
            carry_d = fa_cout;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == RUN);
   assign sum       = sum_q;
   assign cout      = carry_q;

endmodule
